// File: rtl/statreg_wr_ctrl.sv
// Status-flag write controller: clears flags 1..7 after reset, then round-robin
// arbitrates single-flag writes onto the one we/wa/wd port and keeps a shadow copy.
module statreg_wr_ctrl #(
  parameter int NREQ = 4,
  parameter int AW   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ-1:0]   req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              we,
  output logic [AW-1:0]     wa,
  output logic              wd,
  output logic              err_addr0,
  output logic              busy,
  output logic              init_done,
  output logic [7:0]        shadow
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WRITE} state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           cnt_q, cnt_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [NREQ-1:0]         req_ready_q, req_ready_d;
  logic                    we_q, we_d;
  logic [AW-1:0]           wa_q, wa_d;
  logic                    wd_q, wd_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    init_done_q, init_done_d;
  logic [7:0]              shadow_q, shadow_d;

  logic [NREQ-1:0][AW-1:0] addr_arr;
  logic                    found;
  logic [PW-1:0]           win;
  logic [PW:0]             idx;

  assign addr_arr = req_addr;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!found && req_valid[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    req_ready_d = '0;
    we_d        = 1'b0;
    wa_d        = wa_q;
    wd_d        = wd_q;
    err_d       = 1'b0;
    busy_d      = busy_q;
    init_done_d = init_done_q;
    shadow_d    = shadow_q;
    unique case (state_q)
      S_INIT: begin
        // 3-bit counter wraps 7->0, which marks the clear sequence finished
        if (cnt_q != '0) begin
          we_d   = 1'b1;
          wa_d   = cnt_q;
          wd_d   = 1'b0;
          cnt_d  = cnt_q + 1'b1;
          busy_d = 1'b1;
        end else begin
          init_done_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_IDLE: begin
        busy_d = 1'b0;
        if (found) begin
          req_ready_d[win] = 1'b1;
          wa_d    = addr_arr[win];
          wd_d    = req_data[win];
          we_d    = (addr_arr[win] != '0);
          err_d   = (addr_arr[win] == '0);
          ptr_d   = (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
          busy_d  = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (we_q) shadow_d[wa_q] = wd_q;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
    shadow_d[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      cnt_q       <= AW'(1);
      ptr_q       <= '0;
      req_ready_q <= '0;
      we_q        <= 1'b0;
      wa_q        <= '0;
      wd_q        <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
      shadow_q    <= 8'h01;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      req_ready_q <= req_ready_d;
      we_q        <= we_d;
      wa_q        <= wa_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      shadow_q    <= shadow_d;
    end
  end

  assign req_ready = req_ready_q;
  assign we        = we_q;
  assign wa        = wa_q;
  assign wd        = wd_q;
  assign err_addr0 = err_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign shadow    = shadow_q;
endmodule

// File: tb/tb_statreg_wr_ctrl.sv
// Directed bench for statreg_wr_ctrl: init clear, single writes, addr-0 drop,
// round-robin order, pointer wrap and reset during a write.
module tb_statreg_wr_ctrl;
  localparam int NREQ = 4;
  localparam int AW   = 3;

  logic                   clk, rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*AW-1:0]     req_addr;
  logic [NREQ-1:0]        req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   we, wd, err_addr0, busy, init_done;
  logic [AW-1:0]          wa;
  logic [7:0]             shadow;

  int n_chk  = 0;
  int n_fail = 0;

  statreg_wr_ctrl #(.NREQ(NREQ), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .we(we), .wa(wa), .wd(wd),
    .err_addr0(err_addr0), .busy(busy), .init_done(init_done), .shadow(shadow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expects rst_n to have just been released on a falling edge.
  task automatic init_seq();
    for (int i = 1; i <= 7; i++) begin
      cyc();
      chk($sformatf("init_we%0d", i), 32'(we), 32'd1);
      chk($sformatf("init_wa%0d", i), 32'(wa), 32'(i));
      chk($sformatf("init_wd%0d", i), 32'(wd), 32'd0);
      chk($sformatf("init_rdy%0d", i), 32'(req_ready), 32'd0);
      chk($sformatf("init_busy%0d", i), 32'(busy), 32'd1);
      chk($sformatf("init_done%0d", i), 32'(init_done), 32'd0);
    end
    cyc();
    chk("init_end_we", 32'(we), 32'd0);
    chk("init_end_done", 32'(init_done), 32'd1);
    chk("init_end_busy", 32'(busy), 32'd0);
    chk("init_end_shadow", 32'(shadow), 32'h01);
    chk("init_end_rdy", 32'(req_ready), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    // requester 0 holds a request across the whole INIT phase
    req_valid[0] = 1'b1; req_addr[0*AW +: AW] = 3'd3; req_data[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_shadow", 32'(shadow), 32'h01);
    chk("rst_rdy", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    init_seq();
    req_valid = '0;

    // single write: requester 2, flag 5 <= 1 (ptr 0 -> 3)
    req_valid[2] = 1'b1; req_addr[2*AW +: AW] = 3'd5; req_data[2] = 1'b1;
    cyc();
    chk("w5_we", 32'(we), 32'd1);
    chk("w5_wa", 32'(wa), 32'd5);
    chk("w5_wd", 32'(wd), 32'd1);
    chk("w5_rdy", 32'(req_ready), 32'b0100);
    chk("w5_busy", 32'(busy), 32'd1);
    req_valid = '0;
    cyc();
    chk("w5_we_off", 32'(we), 32'd0);
    chk("w5_rdy_off", 32'(req_ready), 32'd0);
    chk("w5_shadow", 32'(shadow), 32'h21);

    // addr 0 request from requester 1 is dropped (ptr 3 -> 2)
    req_valid[1] = 1'b1; req_addr[1*AW +: AW] = 3'd0; req_data[1] = 1'b0;
    cyc();
    chk("a0_err", 32'(err_addr0), 32'd1);
    chk("a0_rdy", 32'(req_ready), 32'b0010);
    chk("a0_we", 32'(we), 32'd0);
    req_valid = '0;
    cyc();
    chk("a0_err_off", 32'(err_addr0), 32'd0);
    chk("a0_shadow", 32'(shadow), 32'h21);
    cyc();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rdy", 32'(req_ready), 32'd0);

    // pointer at 2, requesters 0 and 3 valid: 3 wins first, then 0
    req_valid = 4'b1001;
    req_addr[3*AW +: AW] = 3'd6; req_data[3] = 1'b1;
    req_addr[0*AW +: AW] = 3'd7; req_data[0] = 1'b1;
    cyc();
    chk("wrap_rdy3", 32'(req_ready), 32'b1000);
    chk("wrap_wa6", 32'(wa), 32'd6);
    req_valid[3] = 1'b0;
    cyc();
    chk("wrap_gap", 32'(req_ready), 32'd0);
    cyc();
    chk("wrap_rdy0", 32'(req_ready), 32'b0001);
    chk("wrap_wa7", 32'(wa), 32'd7);
    req_valid = '0;
    cyc();
    chk("wrap_shadow", 32'(shadow), 32'hE1);

    // reset during WRITE: we falls without waiting for a clock edge
    req_valid[2] = 1'b1; req_addr[2*AW +: AW] = 3'd4; req_data[2] = 1'b1;
    cyc();
    chk("mid_we", 32'(we), 32'd1);
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(we), 32'd0);
    chk("mid_rst_shadow", 32'(shadow), 32'h01);
    chk("mid_rst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    init_seq();

    // all four valid, ptr 0: grants 0,1,2,3,0 every 2 cycles
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = AW'(i + 1);
      req_data[i] = 1'b1;
    end
    req_valid = '1;
    for (int g = 0; g < 5; g++) begin
      cyc();
      chk($sformatf("rr_rdy%0d", g), 32'(req_ready), 32'(1 << (g % NREQ)));
      chk($sformatf("rr_wa%0d", g), 32'(wa), 32'((g % NREQ) + 1));
      chk($sformatf("rr_we%0d", g), 32'(we), 32'd1);
      cyc();
      chk($sformatf("rr_gap%0d", g), 32'(we), 32'd0);
      if (g == 3) chk("rr_shadow", 32'(shadow), 32'h1F);
    end
    req_valid = '0;
    cyc();
    chk("rr_final_shadow", 32'(shadow), 32'h1F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
